// File: rtl/wb_mem_bist.sv
// Wishbone burst write/read-back memory tester with first-error capture.
// Optional feature macro: BIST_ERR_CAPTURE_EN (records address/data of the first mismatch).
module wb_mem_bist #(
    parameter int AW  = 26,
    parameter int DW  = 32,
    parameter int LW  = 16,
    parameter int BL  = 8,
    parameter int TMO = 1023
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            sdr_init_done,
    input  logic            start,
    input  logic [AW-1:0]   cfg_base_addr,
    input  logic [LW-1:0]   cfg_len,
    input  logic [DW-1:0]   cfg_seed,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [LW-1:0]   err_cnt,
    output logic [AW-1:0]   err_addr,
    output logic [DW-1:0]   err_data
);
    localparam int SW = DW / 8;
    localparam int SH = $clog2(SW);
    localparam int BW = 5;
    localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_INIT = 3'd1,
        WR_BURST  = 3'd2,
        WR_GAP    = 3'd3,
        RD_BURST  = 3'd4,
        RD_GAP    = 3'd5,
        FINISH    = 3'd6
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [AW-1:0]   base_r;
    logic [LW-1:0]   len_r, idx_r, idx_nxt_s;
    logic [DW-1:0]   seed_r;
    logic [BW-1:0]   brem_r, brem_nxt_s, blen_r, blen_nxt_s;
    logic [TW-1:0]   tmo_r, tmo_nxt_s;
    logic            tmo_hit_s, burst_nxt_s, mismatch_s, launch_s;
    logic            cyc_r, we_r, busy_r, done_r, pass_r, timeout_r;
    logic [AW-1:0]   addr_r, addr_d_s;
    logic [DW-1:0]   dat_r, dat_d_s;
    logic [2:0]      cti_r, cti_d_s;
    logic [LW-1:0]   err_cnt_r;

    // Beats in the next burst: the smaller of BL and the words still to move.
    function automatic logic [BW-1:0] burst_len(input logic [LW-1:0] rem);
        if (rem >= LW'(BL)) begin
            return BW'(BL);
        end else begin
            return BW'(rem);
        end
    endfunction

    assign launch_s   = (state_r == IDLE) && start;
    assign mismatch_s = (state_r == RD_BURST) && wb_ack_i &&
                        (wb_dat_i != (seed_r + DW'(idx_r)));

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, word index, burst beat and stall-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        brem_nxt_s  = brem_r;
        blen_nxt_s  = blen_r;
        tmo_nxt_s   = {TW{1'b0}};
        tmo_hit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = WAIT_INIT;
                    idx_nxt_s   = {LW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_INIT: begin
                if (!sdr_init_done) begin
                    state_nxt_s = WAIT_INIT;
                end else if (len_r == {LW{1'b0}}) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = WR_BURST;
                    idx_nxt_s   = {LW{1'b0}};
                    blen_nxt_s  = burst_len(len_r);
                    brem_nxt_s  = burst_len(len_r);
                end
            end
            WR_BURST, RD_BURST: begin
                if (wb_ack_i) begin
                    idx_nxt_s = idx_r + LW'(1'b1);
                    if (brem_r == BW'(1'b1)) begin
                        state_nxt_s = (state_r == WR_BURST) ? WR_GAP : RD_GAP;
                    end else begin
                        brem_nxt_s = brem_r - BW'(1'b1);
                    end
                end else if (tmo_r == TW'(TMO - 1)) begin
                    tmo_hit_s   = 1'b1;
                    state_nxt_s = FINISH;
                end else begin
                    tmo_nxt_s = tmo_r + TW'(1'b1);
                end
            end
            WR_GAP: begin
                if (idx_r == len_r) begin
                    state_nxt_s = RD_BURST;
                    idx_nxt_s   = {LW{1'b0}};
                    blen_nxt_s  = burst_len(len_r);
                    brem_nxt_s  = burst_len(len_r);
                end else begin
                    state_nxt_s = WR_BURST;
                    blen_nxt_s  = burst_len(len_r - idx_r);
                    brem_nxt_s  = burst_len(len_r - idx_r);
                end
            end
            RD_GAP: begin
                if (idx_r == len_r) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = RD_BURST;
                    blen_nxt_s  = burst_len(len_r - idx_r);
                    brem_nxt_s  = burst_len(len_r - idx_r);
                end
            end
            FINISH:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Bus outputs for the coming cycle, computed from the next state so they leave flops.
    always_comb begin
        burst_nxt_s = (state_nxt_s == WR_BURST) || (state_nxt_s == RD_BURST);
        addr_d_s    = {AW{1'b0}};
        dat_d_s     = {DW{1'b0}};
        cti_d_s     = 3'b000;
        if (burst_nxt_s) begin
            addr_d_s = base_r + (AW'(idx_nxt_s) << SH);
        end else begin
            addr_d_s = {AW{1'b0}};
        end
        if (state_nxt_s == WR_BURST) begin
            dat_d_s = seed_r + DW'(idx_nxt_s);
        end else begin
            dat_d_s = {DW{1'b0}};
        end
        if (!burst_nxt_s || (blen_nxt_s == BW'(1'b1))) begin
            cti_d_s = 3'b000;
        end else if (brem_nxt_s == BW'(1'b1)) begin
            cti_d_s = 3'b111;
        end else begin
            cti_d_s = 3'b010;
        end
    end

    // Datapath, configuration capture and status registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            base_r    <= {AW{1'b0}};
            len_r     <= {LW{1'b0}};
            seed_r    <= {DW{1'b0}};
            idx_r     <= {LW{1'b0}};
            brem_r    <= {BW{1'b0}};
            blen_r    <= {BW{1'b0}};
            tmo_r     <= {TW{1'b0}};
            cyc_r     <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= {AW{1'b0}};
            dat_r     <= {DW{1'b0}};
            cti_r     <= 3'b000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            timeout_r <= 1'b0;
            err_cnt_r <= {LW{1'b0}};
        end else begin
            idx_r  <= idx_nxt_s;
            brem_r <= brem_nxt_s;
            blen_r <= blen_nxt_s;
            tmo_r  <= tmo_nxt_s;
            cyc_r  <= burst_nxt_s;
            we_r   <= (state_nxt_s == WR_BURST);
            addr_r <= addr_d_s;
            dat_r  <= dat_d_s;
            cti_r  <= cti_d_s;
            busy_r <= (state_nxt_s != IDLE);
            done_r <= (state_nxt_s == FINISH);
            if (launch_s) begin
                base_r    <= cfg_base_addr;
                len_r     <= cfg_len;
                seed_r    <= cfg_seed;
                pass_r    <= 1'b0;
                timeout_r <= 1'b0;
                err_cnt_r <= {LW{1'b0}};
            end else begin
                if (tmo_hit_s) begin
                    timeout_r <= 1'b1;
                end
                if (mismatch_s && (err_cnt_r != {LW{1'b1}})) begin
                    err_cnt_r <= err_cnt_r + LW'(1'b1);
                end
                if (state_nxt_s == FINISH) begin
                    pass_r <= (err_cnt_r == {LW{1'b0}}) && !timeout_r && !tmo_hit_s;
                end
            end
        end
    end

`ifdef BIST_ERR_CAPTURE_EN
    logic [AW-1:0] err_addr_r;
    logic [DW-1:0] err_data_r;

    // Only the first mismatch of a run is recorded; later ones just count.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || launch_s) begin
            err_addr_r <= {AW{1'b0}};
            err_data_r <= {DW{1'b0}};
        end else if (mismatch_s && (err_cnt_r == {LW{1'b0}})) begin
            err_addr_r <= addr_r;
            err_data_r <= wb_dat_i;
        end
    end

    assign err_addr = err_addr_r;
    assign err_data = err_data_r;
`else
    assign err_addr = {AW{1'b0}};
    assign err_data = {DW{1'b0}};
`endif

    assign wb_cyc_o  = cyc_r;
    assign wb_stb_o  = cyc_r;
    assign wb_we_o   = we_r;
    assign wb_addr_o = addr_r;
    assign wb_dat_o  = dat_r;
    assign wb_sel_o  = {SW{cyc_r}};
    assign wb_cti_o  = cti_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign timeout   = timeout_r;
    assign err_cnt   = err_cnt_r;
endmodule
